i2c_slave_byte_ctrl: RTL and testbench
======================================

Name: i2c_slave_byte_ctrl

Overview:
I2C target-side byte controller: the responder end of the bus driven by the team's I2C master.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Receives and matches the 7-bit address, then ACKs and receives write bytes or serialises read bytes.
- Drives SDA through an open-drain enable.
- Sits between the I2C pads and a simple byte-wide register/FIFO interface.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit target address matched against the first byte after START.
SYNC_STAGES, 2, flip-flop stages on Scl_i/Sda_i (minimum 2).

Ports:
Clk  input  1  system clock; must be at least 8x the SCL frequency.
Rst_n  input  1  asynchronous active-low reset.
Scl_i  input  1  SCL pad level (asynchronous).
Sda_i  input  1  SDA pad level (asynchronous).
Sda_oe  output  1  1 = pull SDA low; 0 = release.
Ack_en  input  1  1 = ACK received write bytes; 0 = NACK them. Sampled at the 8th-bit SCL rise.
Rx_data  output  8  last received write byte. Valid while Rx_valid=1 and held afterwards.
Rx_valid  output  1  one-Clk pulse per received write byte. Not asserted for the address byte.
Tx_data  input  8  byte to transmit on read; captured on Tx_req.
Tx_req  output  1  one-Clk pulse requesting the next read byte.
Addressed  output  1  high from the address ACK until STOP or repeated START.
Rw  output  1  R/W bit of the current transfer (1 = read).
Stop_det  output  1  one-Clk pulse on STOP.

Behaviour:
- Reset values: Sda_oe=0, Rx_data=0, Rx_valid=0, Tx_req=0, Addressed=0, Rw=0, Stop_det=0, state IDLE, bit counter 0. Reset mid-transfer releases SDA immediately (asynchronous).
- Synchronised lines are scl_s/sda_s. scl_rise/scl_fall are one-Clk pulses on synced edges.
- START: sda_s falls while scl_s=1. STOP: sda_s rises while scl_s=1.
- Data is sampled only on scl_rise. Sda_oe changes only on scl_fall, in the same Clk as the fall is detected.
- START (initial or repeated) from any state:
  - go to ADDR, clear bit counter, Sda_oe=0, Addressed=0.
  - START takes priority over any edge seen in the same Clk.
- STOP from any state: go to IDLE, Sda_oe=0, Addressed=0, Stop_det pulse.
- States:
  - IDLE: ignore edges; wait for START.
  - ADDR: shift 8 bits MSB-first on scl_rise. After bit 8:
    - if address[7:1]==SLAVE_ADDR: latch Rw=bit0, go to ADDR_ACK; if Rw=1, pulse Tx_req in the same Clk.
    - else go to WAIT_STOP.
  - ADDR_ACK:
    - first scl_fall: Sda_oe=1, Addressed=1.
    - next scl_fall ends the ACK bit:
      - Rw=0: Sda_oe=0, go to WR_DATA.
      - Rw=1: capture Tx_data into the shift register, Sda_oe=~Tx_data[7], go to RD_DATA.
  - WR_DATA: shift 8 bits on scl_rise. On bit 8:
    - Rx_data <= byte; Rx_valid pulse.
    - latch Ack_en; go to WR_ACK.
  - WR_ACK:
    - first scl_fall: Sda_oe=latched Ack_en.
    - next scl_fall: Sda_oe=0.
    - next state: WR_DATA if ACKed, else WAIT_STOP.
  - RD_DATA:
    - on each scl_fall after bits 7..1: drive the next bit (Sda_oe=~bit).
    - after the 8th bit's scl_fall: Sda_oe=0, go to RD_ACK.
  - RD_ACK: on scl_rise sample the master response.
    - sda_s=0 (ACK): pulse Tx_req. On the following scl_fall, capture Tx_data, drive bit 7, go to RD_DATA.
    - sda_s=1 (NACK): go to WAIT_STOP with Sda_oe=0.
  - WAIT_STOP: SDA released; leave only on START or STOP.
- Tx_data must be stable from the Tx_req pulse until the next scl_fall, at least 2 Clk later for any legal SCL.
- The bit counter is 3 bits and wraps 7->0 at the byte boundary. It does not count ACK bits.
- Arbitration/clock stretching: not supported. SCL is input only.

Decomposition:
- Package i2c_slave_defines:
  - state encodings (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP; 3-bit).
  - ACK/NACK level constants.
- Sub-module i2c_slave_line_sync: SYNC_STAGES synchronisers plus scl_rise/scl_fall/start/stop pulse generation.

Test Plan:
- Write: START, 0xA0 (addr 0x50, W), 0xA5, STOP, Ack_en=1 -> SDA low in both ACK slots; Rx_data=0xA5 with one Rx_valid pulse; Stop_det pulse; Addressed 1 then 0.
- Mismatch: START, 0xA2, 0x11, STOP -> Sda_oe never 1; no Rx_valid; state WAIT_STOP then IDLE.
- Read: START, 0xA1, Tx_data=0x3C then 0xC3; master ACKs byte 1 and NACKs byte 2 -> bus bits 00111100 then 11000011; exactly two Tx_req pulses; SDA released after the NACK.
- Repeated START: write 0xA0, 0x01, then START, 0xA1 without STOP -> Rw switches to 1, Tx_req pulses, read proceeds; Stop_det not asserted at the repeated START.
- Ack_en=0: START, 0xA0, 0x77 -> Rx_valid pulses with 0x77; 9th bit SDA released (NACK); a further byte produces no Rx_valid.
- Disruption:
  - STOP injected after 4 data bits -> IDLE, no Rx_valid.
  - Rst_n asserted while Sda_oe=1 in ADDR_ACK -> Sda_oe=0 immediately; all outputs at reset values.

Source files
------------

// File: rtl/i2c_slave_defines.sv
// Shared encodings for the I2C target byte controller.
package i2c_slave_defines;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WR_DATA   = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_RD_DATA   = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;
endpackage

// File: rtl/i2c_slave_line_sync.sv
// Pad synchronisers for SCL/SDA plus edge, START and STOP pulse generation.
module i2c_slave_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Scl_i,
  input  logic Sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  logic [SYNC_STAGES-1:0] scl_ff, sda_ff;
  logic scl_s, scl_d, sda_d;

  // Reset to the idle-bus level so release of reset never fakes an edge.
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      scl_ff <= '1;
      sda_ff <= '1;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[SYNC_STAGES-2:0], Scl_i};
      sda_ff <= {sda_ff[SYNC_STAGES-2:0], Sda_i};
      scl_d  <= scl_s;
      sda_d  <= sda_s;
    end

  assign scl_s     = scl_ff[SYNC_STAGES-1];
  assign sda_s     = sda_ff[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~sda_d & sda_s;
endmodule

// File: rtl/i2c_slave_byte_ctrl.sv
// I2C target byte controller: address match, write receive, read serialise.
module i2c_slave_byte_ctrl
  import i2c_slave_defines::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Scl_i,
  input  logic       Sda_i,
  output logic       Sda_oe,
  input  logic       Ack_en,
  output logic [7:0] Rx_data,
  output logic       Rx_valid,
  input  logic [7:0] Tx_data,
  output logic       Tx_req,
  output logic       Addressed,
  output logic       Rw,
  output logic       Stop_det
);
  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       ack_ph, ack_lat;
  logic       sda_s, scl_rise, scl_fall, start, stop;

  i2c_slave_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .Clk(Clk), .Rst_n(Rst_n), .Scl_i(Scl_i), .Sda_i(Sda_i),
    .sda_s(sda_s), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start), .stop_det(stop)
  );

  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      ack_ph    <= 1'b0;
      ack_lat   <= 1'b0;
      Sda_oe    <= 1'b0;
      Rx_data   <= 8'h00;
      Rx_valid  <= 1'b0;
      Tx_req    <= 1'b0;
      Addressed <= 1'b0;
      Rw        <= 1'b0;
      Stop_det  <= 1'b0;
    end else begin
      Rx_valid <= 1'b0;
      Tx_req   <= 1'b0;
      Stop_det <= 1'b0;
      if (start) begin
        state     <= ST_ADDR;
        bit_cnt   <= 3'd0;
        ack_ph    <= 1'b0;
        Sda_oe    <= 1'b0;
        Addressed <= 1'b0;
      end else if (stop) begin
        state     <= ST_IDLE;
        bit_cnt   <= 3'd0;
        ack_ph    <= 1'b0;
        Sda_oe    <= 1'b0;
        Addressed <= 1'b0;
        Stop_det  <= 1'b1;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shreg   <= {shreg[6:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (shreg[6:0] == SLAVE_ADDR) begin
                Rw     <= sda_s;
                Tx_req <= sda_s;
                ack_ph <= 1'b0;
                state  <= ST_ADDR_ACK;
              end else
                state <= ST_WAIT_STOP;
            end
          end
          // First fall opens the ACK slot, second fall closes it.
          ST_ADDR_ACK: if (scl_fall) begin
            if (!ack_ph) begin
              Sda_oe    <= 1'b1;
              Addressed <= 1'b1;
              ack_ph    <= 1'b1;
            end else begin
              ack_ph <= 1'b0;
              if (Rw) begin
                shreg  <= Tx_data;
                Sda_oe <= ~Tx_data[7];
                state  <= ST_RD_DATA;
              end else begin
                Sda_oe <= 1'b0;
                state  <= ST_WR_DATA;
              end
            end
          end
          ST_WR_DATA: if (scl_rise) begin
            shreg   <= {shreg[6:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              Rx_data  <= {shreg[6:0], sda_s};
              Rx_valid <= 1'b1;
              ack_lat  <= Ack_en;
              ack_ph   <= 1'b0;
              state    <= ST_WR_ACK;
            end
          end
          ST_WR_ACK: if (scl_fall) begin
            if (!ack_ph) begin
              Sda_oe <= ack_lat;
              ack_ph <= 1'b1;
            end else begin
              Sda_oe <= 1'b0;
              ack_ph <= 1'b0;
              state  <= ack_lat ? ST_WR_DATA : ST_WAIT_STOP;
            end
          end
          // bit_cnt counts bits the master has sampled; wrap to 0 means byte done.
          ST_RD_DATA: begin
            if (scl_rise)
              bit_cnt <= bit_cnt + 3'd1;
            else if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                Sda_oe <= 1'b0;
                ack_ph <= 1'b0;
                state  <= ST_RD_ACK;
              end else begin
                Sda_oe <= ~shreg[6];
                shreg  <= {shreg[6:0], 1'b0};
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise && !ack_ph) begin
              if (sda_s == ACK_LVL) begin
                Tx_req <= 1'b1;
                ack_ph <= 1'b1;
              end else begin
                Sda_oe <= 1'b0;
                state  <= ST_WAIT_STOP;
              end
            end else if (scl_fall && ack_ph) begin
              shreg  <= Tx_data;
              Sda_oe <= ~Tx_data[7];
              ack_ph <= 1'b0;
              state  <= ST_RD_DATA;
            end
          end
          default: Sda_oe <= 1'b0;
        endcase
      end
    end
endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Directed bench: a bit-banged I2C master against the target byte controller.
module tb_i2c_slave_byte_ctrl;
  import i2c_slave_defines::*;

  localparam int Q = 10;  // Clk cycles per quarter SCL period

  logic Clk = 1'b0, Rst_n = 1'b0;
  logic scl_m = 1'b1, sda_m = 1'b1;
  logic Scl_i, Sda_i, Sda_oe, Ack_en = 1'b1;
  logic [7:0] Rx_data, Tx_data = 8'h00;
  logic Rx_valid, Tx_req, Addressed, Rw, Stop_det;
  int checks = 0, failures = 0;
  int n_rx = 0, n_tx = 0, n_stop = 0, n_oe = 0;

  always #5 Clk = ~Clk;
  assign Scl_i = scl_m;
  assign Sda_i = sda_m & ~Sda_oe;

  i2c_slave_byte_ctrl dut (
    .Clk(Clk), .Rst_n(Rst_n), .Scl_i(Scl_i), .Sda_i(Sda_i), .Sda_oe(Sda_oe),
    .Ack_en(Ack_en), .Rx_data(Rx_data), .Rx_valid(Rx_valid), .Tx_data(Tx_data),
    .Tx_req(Tx_req), .Addressed(Addressed), .Rw(Rw), .Stop_det(Stop_det)
  );

  always @(negedge Clk) begin
    if (Rx_valid) n_rx++;
    if (Tx_req) n_tx++;
    if (Stop_det) n_stop++;
    if (Sda_oe) n_oe++;
  end

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge Clk);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    sda_m = b;  wait_q(1);
    scl_m = 1'b1; wait_q(1);
    s = Sda_i;  wait_q(1);
    scl_m = 1'b0; wait_q(1);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q(1);
    scl_m = 1'b1; wait_q(1);
    sda_m = 1'b0; wait_q(1);
    scl_m = 1'b0; wait_q(1);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q(1);
    scl_m = 1'b1; wait_q(1);
    sda_m = 1'b1; wait_q(1);
  endtask

  // ack = 1 when the target pulled SDA low in the 9th slot
  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic m_ack, input logic [7:0] next);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      b[i] = s;
    end
    Tx_data = next;
    bus_bit(m_ack ? ACK_LVL : NACK_LVL, s);
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; wait_q(1);
    checks++;
    if ({Sda_oe, Rx_data, Rx_valid, Tx_req, Addressed, Rw, Stop_det} !== 14'd0) begin
      failures++; $display("FAIL reset_outputs got %h want 0", {Sda_oe, Rx_data, Rx_valid, Tx_req, Addressed, Rw, Stop_det});
    end
    checks++;
    if (dut.state !== ST_IDLE || dut.bit_cnt !== 3'd0) begin
      failures++; $display("FAIL reset_state got %0d/%0d want IDLE/0", dut.state, dut.bit_cnt);
    end
    Rst_n = 1'b1; wait_q(1);
  endtask

  task automatic test_write();
    logic a1, a2; int rx0, st0;
    rx0 = n_rx; st0 = n_stop;
    i2c_start();
    write_byte(8'hA0, a1);
    checks++;
    if (Addressed !== 1'b1) begin failures++; $display("FAIL wr_addressed got %b want 1", Addressed); end
    write_byte(8'hA5, a2);
    checks++;
    if ({a1, a2} !== 2'b11) begin failures++; $display("FAIL wr_acks got %b want 11", {a1, a2}); end
    checks++;
    if (Rx_data !== 8'hA5 || n_rx - rx0 != 1) begin
      failures++; $display("FAIL wr_rx got %h x%0d want a5 x1", Rx_data, n_rx - rx0);
    end
    i2c_stop(); wait_q(1);
    checks++;
    if (n_stop - st0 != 1 || Addressed !== 1'b0) begin
      failures++; $display("FAIL wr_stop got stops=%0d addr=%b want 1/0", n_stop - st0, Addressed);
    end
  endtask

  task automatic test_mismatch();
    logic a1, a2; int rx0, oe0;
    rx0 = n_rx; oe0 = n_oe;
    i2c_start();
    write_byte(8'hA2, a1);
    write_byte(8'h11, a2);
    checks++;
    if (dut.state !== ST_WAIT_STOP) begin failures++; $display("FAIL mm_wait got %0d want WAIT_STOP", dut.state); end
    i2c_stop(); wait_q(1);
    checks++;
    if (n_oe != oe0 || {a1, a2} !== 2'b00 || n_rx != rx0) begin
      failures++; $display("FAIL mm_quiet got oe=%0d acks=%b rx=%0d want 0/00/0", n_oe - oe0, {a1, a2}, n_rx - rx0);
    end
    checks++;
    if (dut.state !== ST_IDLE) begin failures++; $display("FAIL mm_idle got %0d want IDLE", dut.state); end
  endtask

  task automatic test_read();
    logic a; logic [7:0] b1, b2; int tx0;
    tx0 = n_tx; Tx_data = 8'h3C;
    i2c_start();
    write_byte(8'hA1, a);
    checks++;
    if (a !== 1'b1 || Rw !== 1'b1) begin failures++; $display("FAIL rd_addr got ack=%b rw=%b want 1/1", a, Rw); end
    read_byte(b1, 1'b1, 8'hC3);
    read_byte(b2, 1'b0, 8'h00);
    checks++;
    if (b1 !== 8'h3C) begin failures++; $display("FAIL rd_byte1 got %h want 3c", b1); end
    checks++;
    if (b2 !== 8'hC3) begin failures++; $display("FAIL rd_byte2 got %h want c3", b2); end
    checks++;
    if (n_tx - tx0 != 2) begin failures++; $display("FAIL rd_txreq got %0d want 2", n_tx - tx0); end
    checks++;
    if (Sda_oe !== 1'b0 || dut.state !== ST_WAIT_STOP) begin
      failures++; $display("FAIL rd_release got oe=%b st=%0d want 0/WAIT_STOP", Sda_oe, dut.state);
    end
    i2c_stop(); wait_q(1);
  endtask

  task automatic test_rep_start();
    logic a1, a2, a3; logic [7:0] b; int st0, tx0;
    i2c_start();
    write_byte(8'hA0, a1);
    write_byte(8'h01, a2);
    st0 = n_stop; tx0 = n_tx; Tx_data = 8'h5A;
    i2c_start();
    checks++;
    if (Addressed !== 1'b0) begin failures++; $display("FAIL rs_addr_clear got %b want 0", Addressed); end
    write_byte(8'hA1, a3);
    checks++;
    if ({a1, a2, a3} !== 3'b111 || Rw !== 1'b1) begin
      failures++; $display("FAIL rs_acks got %b rw=%b want 111/1", {a1, a2, a3}, Rw);
    end
    checks++;
    if (n_tx - tx0 != 1 || n_stop != st0) begin
      failures++; $display("FAIL rs_pulses got tx=%0d stop=%0d want 1/0", n_tx - tx0, n_stop - st0);
    end
    read_byte(b, 1'b0, 8'h00);
    checks++;
    if (b !== 8'h5A) begin failures++; $display("FAIL rs_read got %h want 5a", b); end
    i2c_stop(); wait_q(1);
  endtask

  task automatic test_nack_wr();
    logic a1, a2, a3; int rx0;
    Ack_en = 1'b0; rx0 = n_rx;
    i2c_start();
    write_byte(8'hA0, a1);
    write_byte(8'h77, a2);
    checks++;
    if ({a1, a2} !== 2'b10) begin failures++; $display("FAIL nk_acks got %b want 10", {a1, a2}); end
    checks++;
    if (Rx_data !== 8'h77 || n_rx - rx0 != 1) begin
      failures++; $display("FAIL nk_rx got %h x%0d want 77 x1", Rx_data, n_rx - rx0);
    end
    write_byte(8'h12, a3);
    checks++;
    if (a3 !== 1'b0 || n_rx - rx0 != 1) begin
      failures++; $display("FAIL nk_extra got ack=%b rx=%0d want 0/1", a3, n_rx - rx0);
    end
    i2c_stop(); wait_q(1);
    Ack_en = 1'b1;
  endtask

  task automatic test_disrupt();
    logic a, s; int rx0, st0;
    rx0 = n_rx; st0 = n_stop;
    i2c_start();
    write_byte(8'hA0, a);
    for (int i = 0; i < 4; i++) bus_bit(i[0], s);
    i2c_stop(); wait_q(1);
    checks++;
    if (dut.state !== ST_IDLE || n_rx != rx0 || n_stop - st0 != 1) begin
      failures++; $display("FAIL ds_stop got st=%0d rx=%0d stop=%0d want IDLE/0/1", dut.state, n_rx - rx0, n_stop - st0);
    end
    i2c_start();
    for (int i = 7; i >= 0; i--) bus_bit(i == 7 || i == 5, s);
    checks++;
    if (Sda_oe !== 1'b1 || dut.state !== ST_ADDR_ACK) begin
      failures++; $display("FAIL ds_pre_rst got oe=%b st=%0d want 1/ADDR_ACK", Sda_oe, dut.state);
    end
    Rst_n = 1'b0; #1;
    checks++;
    if (Sda_oe !== 1'b0) begin failures++; $display("FAIL ds_async_rel got %b want 0", Sda_oe); end
    checks++;
    if ({Rx_data, Rx_valid, Tx_req, Addressed, Stop_det} !== 12'd0 || dut.state !== ST_IDLE) begin
      failures++; $display("FAIL ds_rst_vals got %h st=%0d want 0/IDLE", {Rx_data, Rx_valid, Tx_req, Addressed, Stop_det}, dut.state);
    end
    scl_m = 1'b1; sda_m = 1'b1; wait_q(1);
    Rst_n = 1'b1; wait_q(1);
  endtask

  initial begin
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_rep_start();
    test_nack_wr();
    test_disrupt();
    test_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
